pipelined_adder: RTL and testbench

//   Parametrised, pipelined WIDTH-bit adder/subtractor for the ALU datapath.

---
 rtl/pipelined_adder_pkg.sv | 18 +
 rtl/pipelined_adder_slice.sv | 28 ++
 rtl/pipelined_adder.sv | 128 ++++++++++++
 tb/tb_pipelined_adder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared ALU definitions for the pipelined adder: op encodings and slice
// geometry helpers used at elaboration.
package pipelined_adder_pkg;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// One CHUNK-bit ripple-carry slice built from full-adder cells. Also exposes
// the carry into its top bit so the last slice can flag signed overflow.
module adder_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  always_comb begin : ripple
    logic w_c;
    // NOTE: blocking assignments here, so each cell's carry is visible to the next loop iteration.
    w_c    = i_cin;
    o_sum  = '0;
    o_cmsb = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      o_cmsb   = w_c;
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Carry-skewed pipelined adder/subtractor: slice k resolves in stage k, and the
// data word carries finished sum bits low and not-yet-added A bits high.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int               CHUNK      = chunk_width(WIDTH, STAGES);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_data  [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic             r_carry [STAGES];
  logic             r_ovf;

  logic             w_prev_valid [STAGES];
  logic [WIDTH-1:0] w_prev_data  [STAGES];
  logic [WIDTH-1:0] w_prev_b     [STAGES];
  logic             w_prev_c     [STAGES];
  logic [WIDTH-1:0] w_stage_data [STAGES];
  logic [CHUNK-1:0] w_sl_a       [STAGES];
  logic [CHUNK-1:0] w_sl_b       [STAGES];
  logic [CHUNK-1:0] w_sl_sum     [STAGES];
  logic             w_sl_cout    [STAGES];
  logic             w_sl_cmsb    [STAGES];

  logic             w_adv;
  logic             w_accept;
  alu_op_e          w_op;
  logic [WIDTH-1:0] w_a0;
  logic [WIDTH-1:0] w_b0;
  logic             w_c0;

  // Single global stall: the whole pipe moves only when the output slot frees up.
  assign w_adv    = !r_valid[STAGES-1] | out_ready;
  assign w_accept = in_valid & w_adv;
  assign in_ready = w_adv;
  assign w_op     = alu_op_e'(in_sub);

  // Idle input cycles enter as all-zero bubbles, so unknown operands never reach state.
  always_comb begin
    w_a0 = '0;
    w_b0 = '0;
    w_c0 = 1'b0;
    if (in_valid) begin
      w_a0 = in_a;
      w_b0 = (w_op == ALU_SUB) ? ~in_b : in_b;
      w_c0 = (w_op == ALU_SUB) ? 1'b1 : in_cin;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_prev_valid[k] = w_accept;
      assign w_prev_data[k]  = w_a0;
      assign w_prev_b[k]     = w_b0;
      assign w_prev_c[k]     = w_c0;
    end else begin : g_next
      assign w_prev_valid[k] = r_valid[k-1];
      assign w_prev_data[k]  = r_data[k-1];
      assign w_prev_b[k]     = r_b[k-1];
      assign w_prev_c[k]     = r_carry[k-1];
    end

    assign w_sl_a[k] = w_prev_data[k][k*CHUNK +: CHUNK];
    assign w_sl_b[k] = w_prev_b[k][k*CHUNK +: CHUNK];

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .i_a   (w_sl_a[k]),
      .i_b   (w_sl_b[k]),
      .i_cin (w_prev_c[k]),
      .o_sum (w_sl_sum[k]),
      .o_cout(w_sl_cout[k]),
      .o_cmsb(w_sl_cmsb[k])
    );

    assign w_stage_data[k] = (w_prev_data[k] & ~(SLICE_MASK << (k*CHUNK)))
                           | (WIDTH'(w_sl_sum[k]) << (k*CHUNK));
  end

  // NOTE: state uses non-blocking assignments, and every register (data included) is reset so no stale beat survives rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_b[k]     <= '0;
        r_carry[k] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_prev_valid[k];
        r_data[k]  <= w_stage_data[k];
        r_b[k]     <= w_prev_b[k];
        r_carry[k] <= w_sl_cout[k];
      end
      r_ovf <= w_sl_cout[STAGES-1] ^ w_sl_cmsb[STAGES-1];
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign out_sum   = r_data[STAGES-1];
  assign out_cout  = r_carry[STAGES-1];
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: 32/4 main instance plus 8/1 and 8/8
// instances for the latency corners.
module tb_pipelined_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_sub, in_cin;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout, out_ovf;
  logic [31:0] out_sum;

  logic       s_in_valid, s_in_sub, s_in_cin;
  logic [7:0] s_in_a, s_in_b;
  logic       s1_in_ready, s1_out_valid, s1_out_cout, s1_out_ovf;
  logic [7:0] s1_out_sum;
  logic       s8_in_ready, s8_out_valid, s8_out_cout, s8_out_ovf;
  logic [7:0] s8_out_sum;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut_s1 (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s1_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_sub(s_in_sub), .in_cin(s_in_cin),
    .out_valid(s1_out_valid), .out_ready(1'b1),
    .out_sum(s1_out_sum), .out_cout(s1_out_cout), .out_ovf(s1_out_ovf)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(8)) u_dut_s8 (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s8_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_sub(s_in_sub), .in_cin(s_in_cin),
    .out_valid(s8_out_valid), .out_ready(1'b1),
    .out_sum(s8_out_sum), .out_cout(s8_out_cout), .out_ovf(s8_out_ovf)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t cur_exp;
  int   n_push = 0;
  int   n_pop  = 0;
  int   n_seen = 0;
  bit   hold_pending = 1'b0;
  bit   last_acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 33-bit add, overflow from the sign rule.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic cin);
    logic [31:0] bp;
    logic [32:0] t;
    exp_t        e;
    bp     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, bp} + {32'd0, (sub ? 1'b1 : cin)};
    e.sum  = t[31:0];
    e.cout = t[32];
    e.ovf  = (a[31] == bp[31]) && (t[31] != a[31]);
    return e;
  endfunction

  // One clock: observe/score at negedge, then step to just after posedge.
  task automatic cycle();
    @(negedge clk);
    if (hold_pending) check("hold_valid", 64'(out_valid), 64'd1);
    if (out_valid) begin
      n_seen++;
      if (q.size() == 0) begin
        check("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        check("sum",  64'(out_sum),  64'(q[0].sum));
        check("cout", 64'(out_cout), 64'(q[0].cout));
        check("ovf",  64'(out_ovf),  64'(q[0].ovf));
        if (out_ready) begin
          void'(q.pop_front());
          n_pop++;
        end
      end
    end
    hold_pending = out_valid && !out_ready;
    last_acc     = in_valid && in_ready;
    if (last_acc) begin
      q.push_back(cur_exp);
      n_push++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic cin, input exp_t e);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_cin   = cin;
    cur_exp  = e;
  endtask

  task automatic drive_vec(input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic cin,
                           input logic [31:0] sum, input logic cout, input logic ovf);
    exp_t e;
    e.sum  = sum;
    e.cout = cout;
    e.ovf  = ovf;
    drive(a, b, sub, cin, e);
  endtask

  task automatic drive_rand();
    logic [31:0] a, b;
    logic        sub, cin;
    a   = $urandom;
    b   = $urandom;
    sub = 1'($urandom_range(0, 1));
    cin = 1'($urandom_range(0, 1));
    drive(a, b, sub, cin, model(a, b, sub, cin));
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 64'(q.size()), 64'd0);
    q.delete();
  endtask

  task automatic small_beat(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic sub, input logic cin,
                            input logic [7:0] esum, input logic ecout, input logic eovf);
    int lat1, lat8;
    lat1 = 0;
    lat8 = 0;
    check({tag, "_ready"}, 64'({s1_in_ready, s8_in_ready}), 64'd3);
    s_in_valid = 1'b1;
    s_in_a     = a;
    s_in_b     = b;
    s_in_sub   = sub;
    s_in_cin   = cin;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (s1_out_valid && lat1 == 0) begin
        lat1 = c;
        check({tag, "_s1_sum"}, 64'(s1_out_sum), 64'(esum));
        check({tag, "_s1_cout"}, 64'(s1_out_cout), 64'(ecout));
        check({tag, "_s1_ovf"}, 64'(s1_out_ovf), 64'(eovf));
      end
      if (s8_out_valid && lat8 == 0) begin
        lat8 = c;
        check({tag, "_s8_sum"}, 64'(s8_out_sum), 64'(esum));
        check({tag, "_s8_cout"}, 64'(s8_out_cout), 64'(ecout));
        check({tag, "_s8_ovf"}, 64'(s8_out_ovf), 64'(eovf));
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_s1_latency"}, 64'(lat1), 64'd1);
    check({tag, "_s8_latency"}, 64'(lat8), 64'd8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, cnt;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
    out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_sub = 1'b0; s_in_cin = 1'b0;
    rst = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    check("rst_out_cout",  64'(out_cout),  64'd0);
    check("rst_out_ovf",   64'(out_ovf),   64'd0);
    check("rst_small_valid", 64'({s1_out_valid, s8_out_valid}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Unknown operands while idle must not create a beat
    in_a = 'x; in_b = 'x; in_sub = 1'bx; in_cin = 1'bx;
    repeat (6) cycle();
    check("x_idle_valid", 64'(out_valid), 64'd0);

    // Single beat latency
    drive_vec(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    cycle();
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      cycle();
      cnt++;
    end
    check("latency_4", 64'(cnt), 64'd4);
    check("first_sum", 64'(out_sum), 64'h8);
    drain("drain_first", 10);

    // Directed carry/borrow/overflow vectors, back to back
    drive_vec(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0); cycle();
    drive_vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1); cycle();
    drive_vec(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0); cycle();
    drive_vec(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0); cycle();
    drive_vec(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1); cycle();
    drive_vec(32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b0); cycle();
    drive_vec(32'h0000_0003, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0); cycle();
    drive_vec(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1); cycle();
    drain("drain_directed", 20);

    // 100 random beats back to back: one result per cycle
    n0 = n_pop;
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      cycle();
    end
    in_valid = 1'b0;
    repeat (4) cycle();
    check("b2b_count", 64'(n_pop - n0), 64'd100);
    check("b2b_queue", 64'(q.size()), 64'd0);

    // Random handshakes on both sides; beats held until accepted
    last_acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (last_acc || !in_valid) begin
        if ($urandom_range(0, 3) != 0) drive_rand();
        else in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    drain("drain_random", 50);
    check("push_pop_balance", 64'(n_push), 64'(n_pop));

    // Fill and stall for 10 cycles
    out_ready = 1'b0;
    n0 = n_push;
    last_acc = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i >= 4) check("stall_in_ready", 64'(in_ready), 64'd0);
      if (last_acc || !in_valid) drive_rand();
      cycle();
    end
    check("stall_fill_count", 64'(n_push - n0), 64'd4);
    drain("drain_stall", 20);

    // Reset with beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      cycle();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_out_sum",   64'(out_sum),   64'd0);
    check("midrst_out_cout",  64'(out_cout),  64'd0);
    check("midrst_out_ovf",   64'(out_ovf),   64'd0);
    q.delete();
    hold_pending = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n0 = n_seen;
    repeat (12) cycle();
    check("post_rst_quiet", 64'(n_seen - n0), 64'd0);

    // Latency corners: STAGES=1 and STAGES=8 at WIDTH=8
    small_beat("w8_add",  8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0);
    small_beat("w8_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    small_beat("w8_sovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    small_beat("w8_sub",  8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    small_beat("w8_subo", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
